// File: rtl/vga_frame_sink.sv
// VGA receive monitor: locks to sync timing, rebuilds pixel coordinates,
// streams active pixels and checks frame geometry with a per-frame checksum.
module vga_frame_sink #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int CKSUM_W  = 16,
  parameter int CW       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank_b,
  input  logic [7:0]         r,
  input  logic [7:0]         g,
  input  logic [7:0]         b,
  output logic               pix_valid,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic [23:0]        pix_rgb,
  output logic               frame_done,
  output logic [CKSUM_W-1:0] frame_sum,
  output logic               locked,
  output logic               err_hcount,
  output logic               err_vcount,
  output logic               err_active,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCK} state_t;

  localparam logic [CW:0]   HT = (CW+1)'(H_TOTAL);
  localparam logic [CW:0]   VT = (CW+1)'(V_TOTAL);
  localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA = CW'(V_ACTIVE);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t             state;
  logic               hs_q;
  logic               vs_q;
  logic [CW-1:0]      hcnt;
  logic [CW-1:0]      vcnt;
  logic [CW-1:0]      ax;
  logic [CW-1:0]      ay;
  logic [CKSUM_W-1:0] acc;

  logic               hfall;
  logic               vfall;
  logic               is_lock;
  logic               cap;
  logic [CW:0]        hlen;
  logic               hbad;
  logic [CW-1:0]      vcnt_close;
  logic               vbad;
  logic               ax_nz;
  logic               ax_bad;
  logic [CW-1:0]      ay_hf;
  logic               ay_bad;
  logic [CW-1:0]      x_cur;
  logic [CW-1:0]      y_cur;
  logic [CW-1:0]      ax_next;
  logic [9:0]         rgb_sum;
  logic [CKSUM_W-1:0] acc_close;
  logic               e_h;
  logic               e_v;
  logic               e_a;
  logic [1:0]         n_err;
  logic [8:0]         cnt_sum;
  logic [7:0]         cnt_next;

  assign hfall      = hs_q & ~hsync;
  assign vfall      = vs_q & ~vsync;
  assign is_lock    = (state == LOCK);
  assign cap        = is_lock & blank_b;
  assign hlen       = {1'b0, hcnt} + 1'b1;
  assign hbad       = (hlen != HT);
  // a coincident hsync fall closes the last line of the closing frame
  assign vcnt_close = hfall ? sat_inc(vcnt) : vcnt;
  assign vbad       = ({1'b0, vcnt_close} != VT);
  assign ax_nz      = (ax != '0);
  assign ax_bad     = ax_nz && (ax != HA);
  assign ay_hf      = (hfall && ax_nz) ? sat_inc(ay) : ay;
  assign ay_bad     = (ay_hf != VA);
  assign x_cur      = hfall ? '0 : ax;
  assign y_cur      = vfall ? '0 : ay_hf;
  assign ax_next    = blank_b ? sat_inc(x_cur) : x_cur;
  assign rgb_sum    = {2'b0, r} + {2'b0, g} + {2'b0, b};
  assign acc_close  = cap ? acc + CKSUM_W'(rgb_sum) : acc;

  assign e_h = is_lock & hfall & hbad;
  assign e_v = is_lock & vfall & vbad;
  assign e_a = is_lock & ((hfall & ax_bad) | (vfall & ~vbad & ay_bad));

  assign n_err    = {1'b0, e_h} + {1'b0, e_v} + {1'b0, e_a};
  assign cnt_sum  = {1'b0, err_count} + {7'b0, n_err};
  assign cnt_next = cnt_sum[8] ? 8'hff : cnt_sum[7:0];

  assign locked = is_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      ax         <= '0;
      ay         <= '0;
      acc        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      err_hcount <= 1'b0;
      err_vcount <= 1'b0;
      err_active <= 1'b0;
      err_count  <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_hcount <= 1'b0;
      err_vcount <= 1'b0;
      err_active <= 1'b0;
      if (pix_en) begin
        hs_q       <= hsync;
        vs_q       <= vsync;
        hcnt       <= hfall ? '0 : sat_inc(hcnt);
        vcnt       <= vfall ? '0 : vcnt_close;
        ax         <= ax_next;
        ay         <= y_cur;
        acc        <= vfall ? '0 : acc_close;
        err_hcount <= e_h;
        err_vcount <= e_v;
        err_active <= e_a;
        err_count  <= cnt_next;
        if (cap) begin
          pix_valid <= 1'b1;
          pix_x     <= x_cur;
          pix_y     <= y_cur;
          pix_rgb   <= {r, g, b};
        end
        if (vfall) begin
          unique case (state)
            SEARCH: state <= ALIGN;
            ALIGN: begin
              if (!vbad) state <= LOCK;
            end
            LOCK: begin
              if (vbad) begin
                state <= ALIGN;
              end else begin
                frame_done <= 1'b1;
                frame_sum  <= acc_close;
              end
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_sink.sv
// Bench for vga_frame_sink: sample-stream reference model, directed
// frame scenarios, random colours and pixel-enable gaps.
module tb_vga_frame_sink;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int VT = 6;
  localparam int CK = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;
  logic          pix_valid;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [23:0]   pix_rgb;
  logic          frame_done;
  logic [CK-1:0] frame_sum;
  logic          locked;
  logic          err_hcount;
  logic          err_vcount;
  logic          err_active;
  logic [7:0]    err_count;

  vga_frame_sink #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA),
    .V_TOTAL(VT), .CKSUM_W(CK), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done),
    .frame_sum(frame_sum), .locked(locked),
    .err_hcount(err_hcount), .err_vcount(err_vcount),
    .err_active(err_active), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state: sample index, phase 0/1/2, line bookkeeping
  int m_idx, m_last_hf, m_phase, m_lines, m_lpix, m_alines, m_acc;
  logic m_prev_hs, m_prev_vs;

  logic          e_valid, e_done, e_locked, e_eh, e_ev, e_ea;
  logic [CW-1:0] e_x, e_y;
  logic [23:0]   e_rgb;
  logic [CK-1:0] e_sum;
  int            e_cnt;

  int obs_valid, obs_done, obs_eh, obs_ev, obs_ea, last_x, last_y;
  int gap_mode;
  bit rgb_rand;
  logic [7:0] fr, fg, fb;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_last_hf = -1; m_phase = 0; m_lines = 0;
    m_lpix = 0; m_alines = 0; m_acc = 0;
    m_prev_hs = 1'b0; m_prev_vs = 1'b0;
    e_valid = 0; e_done = 0; e_locked = 0;
    e_eh = 0; e_ev = 0; e_ea = 0;
    e_x = '0; e_y = '0; e_rgb = '0; e_sum = '0; e_cnt = 0;
  endtask

  task automatic model_step();
    logic hf, vf;
    int ph, close_sum;
    e_valid = 0; e_done = 0; e_eh = 0; e_ev = 0; e_ea = 0;
    if (pix_en) begin
      hf = m_prev_hs & ~hsync;
      vf = m_prev_vs & ~vsync;
      ph = m_phase;
      if (hf) begin
        if (ph == 2 && (m_idx - m_last_hf) != HT) e_eh = 1;
        if (ph == 2 && m_lpix != 0 && m_lpix != HA) e_ea = 1;
        if (m_lpix != 0) m_alines++;
        m_lpix = 0;
        m_last_hf = m_idx;
        m_lines++;
      end
      close_sum = m_acc;
      if (ph == 2 && blank_b) close_sum += int'(r) + int'(g) + int'(b);
      if (vf) begin
        if (ph == 0) m_phase = 1;
        else if (ph == 1) begin
          if (m_lines == VT) m_phase = 2;
        end else if (m_lines != VT) begin
          e_ev = 1;
          m_phase = 1;
        end else begin
          if (m_alines != VA) e_ea = 1;
          e_done = 1;
          e_sum = CK'(close_sum % (1 << CK));
        end
        m_lines = 0; m_alines = 0; m_acc = 0;
      end else begin
        m_acc = close_sum;
      end
      if (ph == 2 && blank_b) begin
        e_valid = 1;
        e_x = CW'(m_lpix);
        e_y = CW'(m_alines);
        e_rgb = {r, g, b};
      end
      if (blank_b) m_lpix++;
      e_cnt = e_cnt + int'(e_eh) + int'(e_ev) + int'(e_ea);
      if (e_cnt > 255) e_cnt = 255;
      m_prev_hs = hsync;
      m_prev_vs = vsync;
      m_idx++;
    end
    e_locked = (m_phase == 2);
  endtask

  task automatic check_all();
    chk("pix_valid", 32'(pix_valid), 32'(e_valid));
    chk("pix_x", 32'(pix_x), 32'(e_x));
    chk("pix_y", 32'(pix_y), 32'(e_y));
    chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_sum", 32'(frame_sum), 32'(e_sum));
    chk("locked", 32'(locked), 32'(e_locked));
    chk("err_hcount", 32'(err_hcount), 32'(e_eh));
    chk("err_vcount", 32'(err_vcount), 32'(e_ev));
    chk("err_active", 32'(err_active), 32'(e_ea));
    chk("err_count", 32'(err_count), 32'(e_cnt));
    if (pix_valid === 1'b1) begin
      obs_valid++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
    end
    if (frame_done === 1'b1) obs_done++;
    if (err_hcount === 1'b1) obs_eh++;
    if (err_vcount === 1'b1) obs_ev++;
    if (err_active === 1'b1) obs_ea++;
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_done = 0; obs_eh = 0; obs_ev = 0; obs_ea = 0;
    last_x = -1; last_y = -1;
  endtask

  task automatic step(input logic en, input logic hs, input logic vs,
                      input logic bl, input logic [7:0] rr,
                      input logic [7:0] gg, input logic [7:0] bb);
    pix_en = en; hsync = hs; vsync = vs; blank_b = bl;
    r = rr; g = gg; b = bb;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  task automatic sample(input logic hs, input logic vs, input logic bl);
    logic [7:0] cr, cg, cb;
    int idle;
    idle = 0;
    if (gap_mode == 1) idle = 1;
    if (gap_mode == 2) idle = int'($urandom_range(0, 2));
    for (int i = 0; i < idle; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
    if (rgb_rand) begin
      cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
    end else begin
      cr = fr; cg = fg; cb = fb;
    end
    step(1'b1, hs, vs, bl, cr, cg, cb);
  endtask

  // hsync low on samples 9..10; vsync falls with the hsync fall of line 4
  task automatic send_frame(input int drop, input int short_ln,
                            input int nstop);
    for (int ln = 0; ln < VT; ln++) begin
      if (ln >= nstop) break;
      if (ln == drop) continue;
      for (int s = 0; s < HT; s++) begin
        if (ln == short_ln && s == 8) continue;
        sample(!(s == 9 || s == 10),
               !((ln == 4 && s >= 9) || (ln == 5 && s < 9)),
               (ln < VA && s < HA));
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    blank_b = 1'b0; r = '0; g = '0; b = '0;
    gap_mode = 0; rgb_rand = 0;
    fr = 8'd1; fg = 8'd2; fb = 8'd3;
    clear_obs();

    do_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    send_frame(-1, -1, VT);
    chk("nom_lock_f1", 32'(locked), 32'd0);
    send_frame(-1, -1, VT);
    chk("nom_lock_f2", 32'(locked), 32'd1);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("nom_valid", obs_valid, 32);
    chk("nom_done", obs_done, 1);
    chk("nom_sum", 32'(frame_sum), 32'd192);
    chk("nom_last_xy", last_x * 16 + last_y, 7 * 16 + 3);
    chk("nom_errs", 32'(err_count), 32'd0);

    do_reset();
    fr = 8'd255; fg = 8'd255; fb = 8'd255;
    send_frame(-1, -1, VT);
    send_frame(-1, -1, VT);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("white_valid", obs_valid, 32);
    chk("white_sum", 32'(frame_sum), 32'd160);

    fr = 8'd1; fg = 8'd2; fb = 8'd3;
    clear_obs();
    send_frame(-1, 1, VT);
    chk("short_eh", obs_eh, 1);
    chk("short_cnt", 32'(err_count), 32'd1);
    chk("short_locked", 32'(locked), 32'd1);
    chk("short_done", obs_done, 1);
    chk("short_sum", 32'(frame_sum), 32'd192);

    clear_obs();
    send_frame(0, -1, VT);
    chk("drop_ev", obs_ev, 1);
    chk("drop_ea", obs_ea, 0);
    chk("drop_locked", 32'(locked), 32'd0);
    chk("drop_done", obs_done, 0);
    chk("drop_cnt", 32'(err_count), 32'd2);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_done", obs_done, 0);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("after_relock_done", obs_done, 1);
    chk("after_relock_cnt", 32'(err_count), 32'd2);

    do_reset();
    gap_mode = 1;
    send_frame(-1, -1, VT);
    send_frame(-1, -1, VT);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("gap_valid", obs_valid, 32);
    chk("gap_done", obs_done, 1);
    chk("gap_sum", 32'(frame_sum), 32'd192);
    chk("gap_last_xy", last_x * 16 + last_y, 7 * 16 + 3);

    do_reset();
    gap_mode = 2;
    rgb_rand = 1;
    send_frame(-1, -1, VT);
    send_frame(-1, -1, VT);
    clear_obs();
    send_frame(-1, -1, VT);
    chk("rand_valid", obs_valid, 32);
    send_frame(-1, 2, VT);
    send_frame(0, -1, VT);
    chk("rand_drop_locked", 32'(locked), 32'd0);

    gap_mode = 0;
    rgb_rand = 0;
    send_frame(-1, -1, VT);
    send_frame(-1, -1, 2);
    chk("mid_locked", 32'(locked), 32'd1);
    do_reset();
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_sum", 32'(frame_sum), 32'd0);
    chk("mid_rst_cnt", 32'(err_count), 32'd0);
    chk("mid_rst_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("mid_rst_rgb", 32'(pix_rgb), 32'd0);
    send_frame(-1, -1, VT);
    chk("mid_relock_f1", 32'(locked), 32'd0);
    send_frame(-1, -1, VT);
    chk("mid_relock_f2", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
